// File: rtl/bus_cmp_pkg.sv
// Shared definitions for the bus comparator: status encoding, CRC defaults
// and the CRC checker state encoding.
package bus_cmp_pkg;

    localparam logic [1:0] ST_BUSY = 2'b10;
    localparam logic [1:0] ST_PASS = 2'b00;
    localparam logic [1:0] ST_FAIL = 2'b01;

    localparam logic [15:0] CRC_POLY_DEF = 16'h1021;
    localparam logic [15:0] CRC_INIT_DEF = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } crcState_t;

endpackage

// File: rtl/crc_check_if.sv
// Request/result channel between the comparator controller and one CRC checker.
interface crc_check_if #(
    parameter int DATA_W = 64,
    parameter int CRC_W  = 16
);
    logic              crcEn;
    logic [DATA_W-1:0] data;
    logic [1:0]        crcStatus;
    logic [CRC_W-1:0]  crcValue;

    modport master (output crcEn, output data, input crcStatus, input crcValue);
    modport slave  (input crcEn, input data, output crcStatus, output crcValue);
endinterface

// File: rtl/crc_check_step.sv
// One-bit non-reflected LFSR update; kept standalone so a transmit-side
// generator can reuse it.
module crc16_serial_step #(
    parameter int CRC_W = 16
) (
    input  logic [CRC_W-1:0] crcIn,
    input  logic             bitIn,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] crcOut
);
    logic fb;

    assign fb     = crcIn[CRC_W-1] ^ bitIn;
    assign crcOut = {crcIn[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);

endmodule

// File: rtl/crc_check.sv
// CRC check responder: serially recomputes the payload CRC of a latched frame
// and reports pass/fail against the frame's CRC trailer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for crcEn low; status busy
// S_SHIFT | one payload bit per clock, MSB first
// S_CHECK | register computed CRC and mismatch flag
// S_DONE  | hold result until crcEn returns high
module crc_check
    import bus_cmp_pkg::*;
#(
    parameter int          DATA_W = 64,
    parameter int          CRC_W  = 16,
    parameter logic [15:0] POLY   = CRC_POLY_DEF,
    parameter logic [15:0] INIT   = CRC_INIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    crc_check_if.slave  bus
);
    localparam int PAY_W = DATA_W - CRC_W;
    localparam int CNT_W = $clog2(PAY_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAY_W - 1);

    crcState_t         state, nextState;
    logic [DATA_W-1:0] frame;
    logic [CRC_W-1:0]  crcReg, crcNext;
    logic [CNT_W-1:0]  bitCnt;
    logic [1:0]        statusQ;
    logic [CRC_W-1:0]  valueQ;
    logic              loadFrame, shiftEn, capture;

    crc16_serial_step #(.CRC_W(CRC_W)) u_step (
        .crcIn  (crcReg),
        .bitIn  (frame[DATA_W-1]),
        .poly   (POLY[CRC_W-1:0]),
        .crcOut (crcNext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        loadFrame = 1'b0;
        shiftEn   = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!bus.crcEn) begin
                    nextState = S_SHIFT;
                    loadFrame = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bus.crcEn) begin
                    nextState = S_IDLE;
                end else begin
                    shiftEn = 1'b1;
                    if (bitCnt == LAST_BIT) nextState = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.crcEn) begin
                    nextState = S_IDLE;
                end else begin
                    capture   = 1'b1;
                    nextState = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.crcEn) nextState = S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
    end

    // The frame shifts left, so after all payload bits the trailer sits in the top CRC_W bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame   <= '0;
            crcReg  <= '0;
            bitCnt  <= '0;
            statusQ <= ST_BUSY;
            valueQ  <= '0;
        end else begin
            if (loadFrame) begin
                frame  <= bus.data;
                crcReg <= INIT[CRC_W-1:0];
                bitCnt <= '0;
            end else if (shiftEn) begin
                frame  <= {frame[DATA_W-2:0], 1'b0};
                crcReg <= crcNext;
                bitCnt <= bitCnt + CNT_W'(1);
            end
            if (capture) begin
                valueQ  <= crcReg;
                statusQ <= {1'b0, crcReg != frame[DATA_W-1 -: CRC_W]};
            end else if (nextState == S_IDLE) begin
                statusQ <= ST_BUSY;
            end
        end
    end

    assign bus.crcStatus = statusQ;
    assign bus.crcValue  = valueQ;

endmodule

// File: tb/tb_crc_check.sv
// Scoreboard bench for crc_check: stimulus pushes expected results, a monitor
// compares them when the busy flag drops.
module tb_crc_check;
    import bus_cmp_pkg::*;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] val;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   edgeCnt = 0;
    int   checks  = 0;
    int   passes  = 0;
    exp_t sb[$];
    logic prevBusy = 1'b1;

    crc_check_if #(.DATA_W(64), .CRC_W(16)) ifc ();

    crc_check dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && prevBusy && !ifc.crcStatus[1]) begin
            if (sb.size() == 0) begin
                check("spuriousResult", 64'(ifc.crcStatus), 64'(ST_BUSY));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resultStatus", 64'(ifc.crcStatus), 64'(e.st));
                check("resultValue", 64'(ifc.crcValue), 64'(e.val));
                check("resultLatency", 64'(edgeCnt - e.acc), 64'd49);
            end
        end
        prevBusy = ifc.crcStatus[1];
    end

    // Caller sits just after a negedge; returns just after a negedge with crcEn high.
    task automatic runCheck(input logic [63:0] d, input logic [1:0] st,
                            input logic [15:0] val, input int hold);
        exp_t e;
        bit   seen;
        ifc.data  = d;
        ifc.crcEn = 1'b0;
        e.st  = st;
        e.val = val;
        e.acc = edgeCnt + 1;
        sb.push_back(e);
        @(negedge clk);
        ifc.data = ~d;
        repeat (48) @(negedge clk);
        check("busyThroughE48", 64'(ifc.crcStatus), 64'(ST_BUSY));
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = !ifc.crcStatus[1];
        end
        check("resultTimeout", 64'(seen), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("holdStatus", 64'(ifc.crcStatus), 64'(st));
            check("holdValue", 64'(ifc.crcValue), 64'(val));
        end
        ifc.crcEn = 1'b1;
        @(negedge clk);
        check("busyAfterRelease", 64'(ifc.crcStatus), 64'(ST_BUSY));
        check("valueKept", 64'(ifc.crcValue), 64'(val));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.crcEn = 1'b1;
        ifc.data  = '0;
        repeat (3) @(negedge clk);
        check("resetStatus", 64'(ifc.crcStatus), 64'(ST_BUSY));
        check("resetValue", 64'(ifc.crcValue), 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idleStatus", 64'(ifc.crcStatus), 64'(ST_BUSY));
        end
        check("idleValue", 64'(ifc.crcValue), 64'd0);

        runCheck(64'h0000_0000_0000_0000, ST_PASS, 16'h0000, 0);
        runCheck(64'h0000_0000_0000_0001, ST_FAIL, 16'h0000, 0);
        runCheck(64'h0000_0000_0001_1021, ST_PASS, 16'h1021, 20);
        runCheck(64'h0000_0000_0002_1021, ST_FAIL, 16'h2042, 0);

        // Abort: crcEn high sampled at E20
        ifc.data  = 64'hDEAD_BEEF_CAFE_1234;
        ifc.crcEn = 1'b0;
        repeat (20) @(negedge clk);
        ifc.crcEn = 1'b1;
        @(negedge clk);
        check("abortStatus", 64'(ifc.crcStatus), 64'(ST_BUSY));
        check("abortValue", 64'(ifc.crcValue), 64'h2042);
        @(negedge clk);
        runCheck(64'h0000_0000_0001_1021, ST_PASS, 16'h1021, 0);

        // Asynchronous reset just after E30
        ifc.data  = 64'h0000_0000_0002_1021;
        ifc.crcEn = 1'b0;
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ifc.crcEn = 1'b1;
        #1;
        check("asyncRstStatus", 64'(ifc.crcStatus), 64'(ST_BUSY));
        check("asyncRstValue", 64'(ifc.crcValue), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        runCheck(64'h0000_0000_0002_1021, ST_FAIL, 16'h2042, 0);

        repeat (60) @(negedge clk);
        check("scoreboardDrained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/crc_check.md
# crc_check

CRC check responder for one bus channel of the bus comparator. The comparator controller drives the active-low enable `crcEn` and a 64-bit frame. This block checks the frame's 16-bit CRC trailer against a bit-serial CRC over the 48-bit payload. It returns the 2-bit `crcStatus` that the controller polls. One instance sits on each channel, producing `crcStatus1` and `crcStatus2` respectively.

## Interface
Parameters:
- `DATA_W`, 64: frame width; CRC trailer in the low bits.
- `CRC_W`, 16: CRC width; payload = `DATA_W-CRC_W` bits (48).
- `POLY`, 16'h1021: generator polynomial, non-reflected; implicit x^16 term.
- `INIT`, 16'h0000: CRC register preset; no final XOR.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `crcEn`  in  1  active-low request, level-held by the controller until it sees a result.
- `data`  in  DATA_W  frame; sampled only at the accepting edge.
- `crcStatus`  out  2  bit1 = result not available (busy), bit0 = CRC mismatch (valid only when bit1=0).
- `crcValue`  out  CRC_W  computed CRC of the last completed check, for logging.

## Operation
- States: IDLE, SHIFT, CHECK, DONE. Reset enters IDLE.
- IDLE:
  - `crcStatus`=2'b10.
  - When `crcEn`==0 at an edge: latch `data` into the frame register, load CRC register with `INIT`, clear the 6-bit bit counter, go to SHIFT.
- SHIFT:
  - One payload bit per clock, MSB first (`data[63]` down to `data[16]`).
  - Per bit: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0).
  - After the 48th bit (counter == 47), go to CHECK.
- CHECK:
  - Register `crcValue`=crc.
  - `crcStatus`={1'b0, crc != frame[15:0]}.
  - Go to DONE.
- DONE:
  - Hold `crcStatus` and `crcValue` while `crcEn`==0.
  - When `crcEn`==1, return to IDLE; `crcStatus` becomes 2'b10 at that edge. `crcValue` is held until the next CHECK.
- Abort: `crcEn` returns to 1 during SHIFT or CHECK → IDLE at that edge, `crcStatus`=2'b10, `crcValue` unchanged.
- No restart from DONE without a 1 on `crcEn` for at least one edge; a continuously low `crcEn` yields exactly one check.
- `data` changes after the accepting edge are ignored.

## Timing
- Reset values: `crcStatus`=2'b10, `crcValue`=0, state IDLE, counter 0, CRC register 0.
- Idle/busy status is 2'b10, never 2'b00. The controller can therefore poll from the first cycle after asserting `crcEn` without a false "done".
- Latency: accepting edge E0; shifts on E1..E48; CHECK registers the result on E49. `crcStatus[1]` falls after E49.
- Minimum turnaround: DONE→IDLE on the first edge with `crcEn`=1. A new `crcEn`=0 is accepted on the following edge.
- Asynchronous reset mid-check: all registers return to reset values immediately; no partial result is ever presented.

## Structure
- Shared package `bus_cmp_pkg`:
  - status encoding constants `ST_BUSY`=2'b10, `ST_PASS`=2'b00, `ST_FAIL`=2'b01, also used by the comparator and output arbiter;
  - default `POLY`/`INIT`;
  - state encoding.
- Natural sub-module `crc16_serial_step`: combinational one-bit LFSR update (crc_in, bit, POLY) → crc_out. It is reusable by a future CRC generator on the transmit side.
- Top: FSM, 6-bit counter, 64-bit frame shift register, output registers.

## Test plan
- Reset: hold `rst`=0, toggle clk → `crcStatus`=2'b10, `crcValue`=0; release, `crcEn`=1 for 10 cycles → unchanged.
- Pass case: `data`=64'h0000_0000_0001_1021, `crcEn`=0 held → `crcStatus` 2'b10 through E48, 2'b00 after E49, `crcValue`=16'h1021. Hold `crcEn` low 20 more cycles → no change, no restart. Raise `crcEn` → 2'b10 next edge.
- Fail case: `data`=64'h0000_0000_0002_1021 → after E49 `crcStatus`=2'b01, `crcValue`=16'h2042.
- Zero frame: `data`=0 → 2'b00, `crcValue`=0. Then `data`=64'h0000_0000_0000_0001 → 2'b01.
- Abort: start a check, raise `crcEn` at E20 → 2'b10 immediately after. Re-assert with the pass frame → correct result 49 edges later.
- Reset mid-operation: assert `rst`=0 at E30 → outputs return to reset values asynchronously. After release, a fresh check completes normally.
